// File: rtl/muldiv_ctrl_if.sv
// Handshake/result bundle between the EX stage and the HI/LO mult/div sequencer.
interface muldiv_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    // EX stage side: issues operations, consumes results
    modport master (
        output start, op, a, b, flush,
        input  stall, busy, done, hi, lo, div_zero
    );

    // Sequencer side
    modport slave (
        input  start, op, a, b, flush,
        output stall, busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: registered multiply, restoring divide, sign fix-up.
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [1:0] OP_MULT = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state;
    logic               mul_signed_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               div_zero_q;

    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [PROD_W-1:0]  a_ext;
    logic [PROD_W-1:0]  b_ext;
    logic [PROD_W-1:0]  prod;
    logic [WIDTH:0]     rem_sh;
    logic               sub_ok;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand conditioning, product, one divide step and sign fix-up
    always_comb begin
        accept  = (state == S_IDLE) && bus.start && !bus.flush;
        a_neg   = !bus.op[0] && bus.a[WIDTH-1];
        b_neg   = !bus.op[0] && bus.b[WIDTH-1];
        a_abs   = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        b_abs   = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

        a_ext   = mul_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = mul_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = a_ext * b_ext;

        // remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        sub_ok  = (rem_sh >= {1'b0, dvsr_q});
        rem_nx  = sub_ok ? WIDTH'(rem_sh - {1'b0, dvsr_q}) : rem_sh[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], sub_ok};

        quo_fix = q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            mul_signed_q <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            div_zero_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_signed_q <= (bus.op == OP_MULT);
                        a_q          <= bus.a;
                        b_q          <= bus.b;
                        rem_q        <= '0;
                        quo_q        <= a_abs;
                        dvsr_q       <= b_abs;
                        q_neg_q      <= a_neg ^ b_neg;
                        r_neg_q      <= a_neg;
                        cnt_q        <= '0;
                        div_zero_q   <= 1'b0;
                        state        <= bus.op[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        {hi_q, lo_q} <= prod;
                        state        <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        // divide by zero: quotient all ones, remainder is the raw dividend
                        if (dvsr_q == '0) begin
                            lo_q       <= '1;
                            hi_q       <= a_q;
                            div_zero_q <= 1'b1;
                        end else begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pipeline hold and result outputs
    assign bus.stall    = !bus.flush &&
                          (accept || (state == S_MUL) || (state == S_DIV) || (state == S_FIX));
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE) && !bus.flush;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for the MULT/MULTU/DIV/DIVU path feeding the HI/LO register pair. It is activated when the decoder asserts hilowrite=2'b11.
- Contains a registered multiplier stage, an iterative restoring divider, and sign fix-up logic.
- Holds the pipeline with a stall while busy. In the completion cycle it presents HI/LO results with a one-cycle write pulse.
- Sits in the EX stage, beside the ALU.

Parameters:
- WIDTH, 32, operand width and result width; the divider iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage instruction is mult/div (hilowrite==2'b11) and valid.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand or dividend).
- b  input  WIDTH  rt operand (multiplier or divisor).
- flush  input  1  exception/flush; aborts any operation in progress.
- stall  output  1  freeze PC/IF/ID/EX while high.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse; hi/lo valid; HI/LO write enable.
- hi  output  WIDTH  HI result (product high word or remainder).
- lo  output  WIDTH  LO result (product low word or quotient).
- div_zero  output  1  valid with done; divisor was zero.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, hi=0, lo=0, done=0, div_zero=0, iteration counter=0, stall=0, busy=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - On start=1 and flush=0, latch op, a and b.
  - MULT/MULTU -> MUL. DIV/DIVU -> DIV with counter=0.
  - For DIV, latch the absolute values of a and b, plus the quotient and remainder sign bits.
- MUL: register the 2*WIDTH product (signed for MULT, unsigned for MULTU) into {hi,lo}. Next state DONE.
- DIV:
  - One restoring shift-subtract step per cycle on the {remainder, quotient} register.
  - Counter increments each cycle. After step WIDTH (counter==WIDTH-1) -> FIX.
- FIX (signed ops only):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Quotient truncates toward zero. The remainder takes the dividend's sign.
  - Load lo=quotient, hi=remainder. Next state DONE.
- Divide by zero:
  - Iterations still run, giving constant latency.
  - FIX forces lo={WIDTH{1}}, hi=a and sets div_zero=1.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0. No flag is raised.
- DONE:
  - done=1 and stall=0, so the instruction leaves EX this cycle.
  - start is ignored, because it is the same instruction.
  - Next state IDLE; done deasserts.
- stall is combinational: (state==IDLE & start & ~flush) | state in {MUL, DIV, FIX}.
- Latency, measured from the start cycle T0:
  - MULT/MULTU: stall on T0–T1, done on T2.
  - DIV/DIVU: stall on T0–T(WIDTH+1), done on T(WIDTH+2). That is T34 for WIDTH=32.
- Flush:
  - flush=1 in any state returns to IDLE on the next edge. done is not produced and stall is low that cycle.
  - hi and lo are left unchanged.
  - In DONE, flush suppresses done.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE, with no bubble required.
- hi and lo hold their last values between operations. div_zero clears when a new operation is accepted.
- A mid-operation reset aborts immediately to the reset values.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> done at T2: hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall high T0–T1.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> done at T34: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); stall high T0–T33.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero=1 with done.
- DIVU a=100, b=7 with flush pulsed at T10 -> IDLE at T11, no done, hi/lo unchanged; then an immediate MULTU 6*7 -> lo=42, hi=0.
- Reset: rst low at T5 of a DIV -> asynchronous IDLE, stall=0, hi=lo=0, done=0. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
